// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and constants for the four-requester round-robin grant controller.
package rr_grant_ctrl_pkg;

   localparam int NREQ             = 4;
   localparam int IDX_W            = 2;
   localparam int MAX_HOLD_DEFAULT = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_prio_enc4.sv
// Rotating-priority encoder: searches ptr+1, ptr+2, ptr+3, ptr (mod 4) for the first request.
module rr_prio_enc4
   import rr_grant_ctrl_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] win_idx,
   output logic             any_req
);

   logic [IDX_W-1:0] cand;

   // Walk from the lowest priority slot to the highest so the last hit is the winner.
   always_comb begin
      win_idx = ptr;
      cand    = ptr;
      any_req = |req;
      for (int i = NREQ; i >= 1; i--) begin
         cand = ptr + IDX_W'(i);
         if (req[cand]) begin
            win_idx = cand;
         end
      end
   end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter with grant hold while requested and a forced release after MAX_HOLD cycles.
module rr_grant_ctrl
   import rr_grant_ctrl_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   state_t           state_reg;
   logic [IDX_W-1:0] ptr_reg;
   logic [CNT_W-1:0] hold_cnt_reg;
   logic [NREQ-1:0]  gnt_reg;
   logic [IDX_W-1:0] gnt_idx_reg;
   logic             gnt_valid_reg;

   logic [IDX_W-1:0] arb_ptr;
   logic [IDX_W-1:0] win_idx;
   logic             any_req;
   logic             hold_ok;

   // While granting, re-arbitration starts after the current holder, so the holder comes last.
   assign arb_ptr = (state_reg == ST_GRANT) ? gnt_idx_reg : ptr_reg;

   assign hold_ok = req[gnt_idx_reg] &&
                    ((MAX_HOLD == 0) || (hold_cnt_reg < CNT_W'(MAX_HOLD)));

   rr_prio_enc4 u_enc (
      .req     (req),
      .ptr     (arb_ptr),
      .win_idx (win_idx),
      .any_req (any_req)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         ptr_reg       <= IDX_W'(NREQ - 1);
         hold_cnt_reg  <= '0;
         gnt_reg       <= '0;
         gnt_idx_reg   <= '0;
         gnt_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (any_req) begin
                  state_reg     <= ST_GRANT;
                  gnt_idx_reg   <= win_idx;
                  gnt_reg       <= idx_to_onehot(win_idx);
                  gnt_valid_reg <= 1'b1;
                  hold_cnt_reg  <= CNT_W'(1);
               end
            end
            ST_GRANT: begin
               if (hold_ok) begin
                  if (hold_cnt_reg != '1) begin
                     hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                  end
               end else begin
                  ptr_reg <= gnt_idx_reg;
                  if (any_req) begin
                     gnt_idx_reg  <= win_idx;
                     gnt_reg      <= idx_to_onehot(win_idx);
                     hold_cnt_reg <= CNT_W'(1);
                  end else begin
                     // gnt_idx deliberately keeps the last served index when going idle.
                     state_reg     <= ST_IDLE;
                     gnt_reg       <= '0;
                     gnt_valid_reg <= 1'b0;
                     hold_cnt_reg  <= '0;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_reg;
   assign gnt_idx   = gnt_idx_reg;
   assign gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: one instance with MAX_HOLD=4, one with the timeout disabled.
module tb_rr_grant_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] req;

   logic [3:0] gnt_a,   gnt_b;
   logic [1:0] idx_a,   idx_b;
   logic       valid_a, valid_b;

   int checks   = 0;
   int failures = 0;

   rr_grant_ctrl #(.MAX_HOLD(4), .CNT_W(4)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt_a),
      .gnt_idx   (idx_a),
      .gnt_valid (valid_a)
   );

   rr_grant_ctrl #(.MAX_HOLD(0), .CNT_W(4)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt_b),
      .gnt_idx   (idx_b),
      .gnt_valid (valid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Packed as {gnt, gnt_idx, gnt_valid}.
   function automatic logic [6:0] exp_grant(input int idx);
      logic [3:0] one;
      one = 4'b0001;
      return {one << idx, 2'(idx), 1'b1};
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s: gnt/idx/valid got %b_%b_%b required %b_%b_%b",
                  tag, obs[6:3], obs[2:1], obs[0], exp[6:3], exp[2:1], exp[0]);
         $error("check %s", tag);
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      step();
      step();
      chk("reset_a", {gnt_a, idx_a, valid_a}, 7'b0000_00_0);
      chk("reset_b", {gnt_b, idx_b, valid_b}, 7'b0000_00_0);

      // Single requester granted after one edge, then released to idle.
      rst = 1'b0;
      req = 4'b0001;
      step();
      $display("txn single_grant req=%b gnt=%b idx=%0d valid=%b", req, gnt_a, idx_a, valid_a);
      chk("single_grant", {gnt_a, idx_a, valid_a}, exp_grant(0));
      req = 4'b0000;
      step();
      $display("txn release_idle req=%b gnt=%b idx=%0d valid=%b", req, gnt_a, idx_a, valid_a);
      chk("release_idle", {gnt_a, idx_a, valid_a}, 7'b0000_00_0);

      // From reset, 0110 grants requester 1; dropping it hands over to 2 without a gap.
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = 4'b0110;
      step();
      $display("txn first_0110 req=%b gnt=%b idx=%0d valid=%b", req, gnt_a, idx_a, valid_a);
      chk("first_0110", {gnt_a, idx_a, valid_a}, exp_grant(1));
      req = 4'b0100;
      step();
      $display("txn handover req=%b gnt=%b idx=%0d valid=%b", req, gnt_a, idx_a, valid_a);
      chk("handover", {gnt_a, idx_a, valid_a}, exp_grant(2));

      // Reset while requester 2 holds.
      req = 4'b1111;
      rst = 1'b1;
      step();
      $display("txn mid_reset req=%b gnt=%b idx=%0d valid=%b", req, gnt_a, idx_a, valid_a);
      chk("mid_reset_a", {gnt_a, idx_a, valid_a}, 7'b0000_00_0);
      chk("mid_reset_b", {gnt_b, idx_b, valid_b}, 7'b0000_00_0);
      rst = 1'b0;
      step();
      $display("txn post_reset req=%b gnt=%b idx=%0d valid=%b", req, gnt_a, idx_a, valid_a);
      chk("post_reset_first", {gnt_a, idx_a, valid_a}, exp_grant(0));

      // All requesting: 4-cycle grants rotating 0,1,2,3,0; the no-timeout instance never moves.
      for (int k = 0; k < 20; k++) begin
         $display("txn rotate k=%0d req=%b gnt_a=%b gnt_b=%b", k, req, gnt_a, gnt_b);
         chk($sformatf("rotate_a_%0d", k), {gnt_a, idx_a, valid_a}, exp_grant((k / 4) % 4));
         chk($sformatf("rotate_b_%0d", k), {gnt_b, idx_b, valid_b}, exp_grant(0));
         step();
      end

      // Lone holder re-granted at each timeout, then 1001 at the boundary passes to requester 0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = 4'b1000;
      for (int k = 0; k < 12; k++) begin
         step();
         $display("txn lone k=%0d req=%b gnt=%b idx=%0d valid=%b", k, req, gnt_a, idx_a, valid_a);
         chk($sformatf("lone_%0d", k), {gnt_a, idx_a, valid_a}, exp_grant(3));
      end
      req = 4'b1001;
      step();
      $display("txn boundary req=%b gnt_a=%b gnt_b=%b", req, gnt_a, gnt_b);
      chk("boundary_a", {gnt_a, idx_a, valid_a}, exp_grant(0));
      chk("boundary_b", {gnt_b, idx_b, valid_b}, exp_grant(3));

      // Timeout disabled: requester 1 keeps the grant although requester 0 also asks.
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = 4'b0010;
      step();
      chk("nohold_first_b", {gnt_b, idx_b, valid_b}, exp_grant(1));
      chk("nohold_first_a", {gnt_a, idx_a, valid_a}, exp_grant(1));
      req = 4'b0011;
      for (int n = 1; n <= 20; n++) begin
         step();
         $display("txn nopreempt n=%0d req=%b gnt_a=%b gnt_b=%b", n, req, gnt_a, gnt_b);
         chk($sformatf("nopreempt_b_%0d", n), {gnt_b, idx_b, valid_b}, exp_grant(1));
         chk($sformatf("alternate_a_%0d", n), {gnt_a, idx_a, valid_a},
             exp_grant(((n / 4) % 2 == 1) ? 0 : 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Four-requester round-robin arbiter for a shared resource; grant select is a 2-bit index plus its one-hot decode.
- Samples `req[3:0]`, picks a winner with rotating priority and holds the grant while the winner keeps requesting.
- Forces release after `MAX_HOLD` cycles so no requester starves others.
- Sits between requesting blocks and the resource's 2-to-4 select decode.

Parameters:
- NREQ, 4, number of requesters (fixed at 4 in this revision).
- IDX_W, 2, width of the grant index.
- MAX_HOLD, 8, maximum consecutive cycles one grant is held; 0 disables the timeout.
- CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit n is requester n.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- gnt_idx  output  2  registered index of the granted requester.
- gnt_valid  output  1  high while any grant is active.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high; it is sampled only on the rising edge of `clk`.
- Reset values: gnt=0000, gnt_idx=00, gnt_valid=0, state=IDLE, hold_cnt=0.
  - ptr (last-served index) resets to 3, so requester 0 has top priority after reset.
- State IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise pick the winner by searching ptr+1, ptr+2, ptr+3, ptr (all mod 4).
  - At that edge: go to GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=1.
  - Latency: a request first sampled at edge k is granted in the outputs after edge k.
- State GRANT, hold condition: req[gnt_idx]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD).
  - Keep the grant and increment hold_cnt, saturating at the max counter value.
- State GRANT, release condition: req[gnt_idx]=0, or hold_cnt==MAX_HOLD with MAX_HOLD!=0.
  - ptr<=gnt_idx.
  - Re-arbitrate in the same edge, searching from gnt_idx+1.
  - If a winner exists: stay in GRANT, load the new gnt_idx, hold_cnt=1. There is no idle gap (back-to-back grants).
  - If no winner exists: go to IDLE, gnt=0000, gnt_valid=0, gnt_idx keeps its last value.
- Timeout with only the current holder requesting:
  - The holder is re-granted (it is last in the search order), hold_cnt=1.
  - gnt stays continuously asserted.
- Invariant: gnt == (gnt_valid ? 1<<gnt_idx : 0000) on every cycle. gnt is never multi-hot.
- Requests that appear or change mid-grant do not preempt the holder.
- Reset mid-grant:
  - At the next edge all outputs are cleared and ptr=3, regardless of req.
  - The first grant after reset deasserts follows the IDLE rules.
- All outputs come straight from flops; no combinational path from req to outputs.

Decomposition:
- Shared package / include:
  - State encodings: ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NREQ, IDX_W, default MAX_HOLD.
- Sub-module `rr_prio_enc4` (combinational):
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: win_idx[1:0] and any_req.
  - Search order: ptr+1 upward with wrap.
- One-hot gnt is decoded from the next-state index inside rr_grant_ctrl and registered there.

Test Plan:
- Reset, then req=0001 held: after one edge gnt=0001, gnt_idx=00, gnt_valid=1. Drop req to 0000: after the next edge gnt=0000, gnt_valid=0.
- From reset, req=0110 held: first grant gnt=0010 (idx 1). Drop req[1]: the next edge gives gnt=0100 with gnt_valid never dropping.
- MAX_HOLD=4, req=1111 held:
  - Grants rotate 0001→0010→0100→1000→0001.
  - Each grant lasts exactly 4 cycles; gnt_valid is continuous.
- MAX_HOLD=4, only req=1000 held for 12 cycles:
  - gnt=1000 for all 12 cycles and hold_cnt wraps to 1 every 4 cycles.
  - Then drive req=1001 at the timeout boundary: the next grant is 0001.
- Reset mid-operation: while gnt=0100, assert rst for one cycle with req=1111.
  - Outputs are 0000/00/0 after that edge.
  - After rst falls, the first grant is 0001 (ptr reset to 3).
- MAX_HOLD=0, req=0010 held for 20 cycles while req[0] also asserted: gnt=0010 throughout, no preemption.
